// File: rtl/acc_seq_pkg.sv
// Shared constants for the accumulator sequencer: state encodings and default widths.
package acc_seq_pkg;

    localparam int unsigned DefWidth = 16;
    localparam int unsigned DefCntW  = 4;

    localparam logic [2:0] StIdle = 3'd0;
    localparam logic [2:0] StClr  = 3'd1;
    localparam logic [2:0] StWait = 3'd2;
    localparam logic [2:0] StLoad = 3'd3;
    localparam logic [2:0] StAdd  = 3'd4;
    localparam logic [2:0] StFin  = 3'd5;
    localparam logic [2:0] StDone = 3'd6;

endpackage

// File: rtl/acc_sequencer.sv
// Drives load/transfer strobes of the 16-bit accumulator for a burst of operands.
// Define ACC_SEQ_OVF_EN to build the sticky overflow shadow sum; otherwise ovf_o is tied low.
module acc_sequencer
    import acc_seq_pkg::*;
#(
    parameter int unsigned WIDTH = DefWidth,
    parameter int unsigned CNT_W = DefCntW
) (
    input  logic             clk_i,
    input  logic             clear_i,
    input  logic             start_i,
    input  logic [CNT_W-1:0] n_ops_i,
    input  logic             op_valid_i,
    input  logic [WIDTH-1:0] op_data_i,
    output logic             op_ready_o,
    output logic [WIDTH-1:0] acc_in_o,
    output logic             acc_load_o,
    output logic             acc_transf_o,
    output logic             acc_clear_n_o,
    input  logic [WIDTH-1:0] acc_out_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] result_o,
    output logic             ovf_o
);

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] acc_in_q, acc_in_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             clear_n_q, load_q, transf_q;

    always_comb begin
        state_d  = state_q;
        rem_d    = rem_q;
        acc_in_d = acc_in_q;
        result_d = result_q;
        case (state_q)
            StIdle: begin
                if (start_i) begin
                    rem_d   = n_ops_i;
                    state_d = StClr;
                end
            end
            StClr:  state_d = (rem_q == '0) ? StFin : StWait;
            StWait: begin
                if (op_valid_i) begin
                    acc_in_d = op_data_i;
                    state_d  = StLoad;
                end
            end
            StLoad: state_d = StAdd;
            StAdd: begin
                rem_d   = rem_q - CNT_W'(1);
                state_d = (rem_q > CNT_W'(1)) ? StWait : StFin;
            end
            StFin: begin
                result_d = acc_out_i;
                state_d  = StDone;
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Strobes are registered from the next state so each is a clean flop output.
    always_ff @(posedge clk_i) begin
        if (clear_i) begin
            state_q   <= StIdle;
            rem_q     <= '0;
            acc_in_q  <= '0;
            result_q  <= '0;
            clear_n_q <= 1'b1;
            load_q    <= 1'b0;
            transf_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            rem_q     <= rem_d;
            acc_in_q  <= acc_in_d;
            result_q  <= result_d;
            clear_n_q <= (state_d != StClr);
            load_q    <= (state_d == StLoad);
            transf_q  <= (state_d == StAdd);
        end
    end

`ifdef ACC_SEQ_OVF_EN
    logic [WIDTH:0] shadow_q, shadow_d;
    logic           ovf_q, ovf_d;

    always_comb begin
        shadow_d = shadow_q;
        ovf_d    = ovf_q;
        if (state_q == StClr) begin
            shadow_d = '0;
            ovf_d    = 1'b0;
        end else if (state_q == StAdd) begin
            shadow_d = shadow_q + {1'b0, acc_in_q};
            ovf_d    = ovf_q | shadow_d[WIDTH];
        end
    end

    always_ff @(posedge clk_i) begin
        if (clear_i) begin
            shadow_q <= '0;
            ovf_q    <= 1'b0;
        end else begin
            shadow_q <= shadow_d;
            ovf_q    <= ovf_d;
        end
    end

    assign ovf_o = ovf_q;
`else
    assign ovf_o = 1'b0;
`endif

    assign op_ready_o    = (state_q == StWait);
    assign busy_o        = (state_q != StIdle);
    assign done_o        = (state_q == StDone);
    assign acc_in_o      = acc_in_q;
    assign result_o      = result_q;
    assign acc_clear_n_o = clear_n_q;
    assign acc_load_o    = load_q;
    assign acc_transf_o  = transf_q;

endmodule

// File: tb/tb_acc_sequencer.sv
// Directed bench for acc_sequencer wired to a behavioural load/transfer accumulator.
module tb_acc_sequencer;

    logic        clk = 1'b0;
    logic        clear, start, op_valid;
    logic [3:0]  n_ops;
    logic [15:0] op_data;
    logic        op_ready, acc_load, acc_transf, acc_clear_n, busy, done, ovf;
    logic [15:0] acc_in, acc_out, result;

    logic [15:0] acc_reg, acc_sum;
    logic [15:0] op_list [4];
    int          n_cmp = 0;
    int          n_bad = 0;

`ifdef ACC_SEQ_OVF_EN
    localparam logic OvfExp = 1'b1;
`else
    localparam logic OvfExp = 1'b0;
`endif

    always #5 clk = ~clk;

    acc_sequencer dut (
        .clk_i         (clk),
        .clear_i       (clear),
        .start_i       (start),
        .n_ops_i       (n_ops),
        .op_valid_i    (op_valid),
        .op_data_i     (op_data),
        .op_ready_o    (op_ready),
        .acc_in_o      (acc_in),
        .acc_load_o    (acc_load),
        .acc_transf_o  (acc_transf),
        .acc_clear_n_o (acc_clear_n),
        .acc_out_i     (acc_out),
        .busy_o        (busy),
        .done_o        (done),
        .result_o      (result),
        .ovf_o         (ovf)
    );

    // Accumulator: load latches the operand, transfer adds it into the sum.
    always_ff @(posedge clk) begin
        if (!acc_clear_n) begin
            acc_sum <= '0;
        end else begin
            if (acc_load)   acc_reg <= acc_in;
            if (acc_transf) acc_sum <= acc_sum + acc_reg;
        end
    end
    assign acc_out = acc_sum;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        check_eq({tag, "_ready"},  op_ready,    0);
        check_eq({tag, "_acc_in"}, acc_in,      0);
        check_eq({tag, "_load"},   acc_load,    0);
        check_eq({tag, "_transf"}, acc_transf,  0);
        check_eq({tag, "_clr_n"},  acc_clear_n, 1);
        check_eq({tag, "_busy"},   busy,        0);
        check_eq({tag, "_done"},   done,        0);
        check_eq({tag, "_result"}, result,      0);
        check_eq({tag, "_ovf"},    ovf,         0);
    endtask

    task automatic run_burst(input string tag, input int n, input int stall,
                             input logic [15:0] exp_res, input logic exp_ovf);
        int   idx = 0;
        int   waited = 0;
        int   cyc = 0;
        bit   got_done = 0;
        bit   stalled = 0;
        logic prev_load = 1'b0;
        @(negedge clk);
        start    = 1'b1;
        n_ops    = 4'(n);
        op_valid = 1'b0;
        while (!got_done && cyc < 200) begin
            @(negedge clk);
            start = 1'b0;
            n_ops = 4'hF;
            cyc++;
            check_eq({tag, "_clr_n"}, acc_clear_n, (cyc == 1) ? 0 : 1);
            if (stalled) begin
                check_eq({tag, "_stall_ready"},  op_ready,   1);
                check_eq({tag, "_stall_load"},   acc_load,   0);
                check_eq({tag, "_stall_transf"}, acc_transf, 0);
            end
            if (acc_load)   check_eq({tag, "_acc_in"}, acc_in, op_list[idx-1]);
            if (acc_transf) check_eq({tag, "_ld_before_tr"}, prev_load, 1);
            if (prev_load)  check_eq({tag, "_tr_after_ld"}, acc_transf, 1);
            prev_load = acc_load;
            stalled   = 0;
            if (done) begin
                got_done = 1;
                check_eq({tag, "_latency"}, cyc, 1 + n * (3 + stall) + 2);
                check_eq({tag, "_result"},  result, exp_res);
                check_eq({tag, "_ovf"},     ovf, exp_ovf);
                op_valid = 1'b0;
            end else if (op_ready && idx < n) begin
                if (waited < stall) begin
                    op_valid = 1'b0;
                    waited++;
                    stalled = 1;
                end else begin
                    op_valid = 1'b1;
                    op_data  = op_list[idx];
                    idx++;
                    waited = 0;
                end
            end else begin
                op_valid = 1'b0;
                op_data  = 16'hDEAD;
            end
        end
        check_eq({tag, "_done_seen"}, got_done, 1);
        @(negedge clk);
        check_eq({tag, "_done_pulse"}, done, 0);
        check_eq({tag, "_idle"}, busy, 0);
    endtask

    task automatic run_abort();
        int cyc = 0;
        int loads = 0;
        int idx = 0;
        bit hit = 0;
        op_list[0] = 16'd1;
        op_list[1] = 16'd2;
        @(negedge clk);
        start = 1'b1;
        n_ops = 4'd2;
        while (!hit && cyc < 50) begin
            @(negedge clk);
            cyc++;
            start = (cyc == 3);
            n_ops = (cyc == 3) ? 4'd9 : 4'd2;
            if (acc_load) loads++;
            if (acc_load && loads == 2) begin
                hit = 1;
                check_eq("abort_load_cycle", cyc, 6);
                check_eq("abort_busy", busy, 1);
                clear    = 1'b1;
                op_valid = 1'b0;
            end else if (op_ready) begin
                op_valid = 1'b1;
                op_data  = op_list[idx];
                idx++;
            end else begin
                op_valid = 1'b0;
            end
        end
        check_eq("abort_hit", hit, 1);
        start = 1'b0;
        @(negedge clk);
        clear = 1'b0;
        check_reset("abort");
    endtask

    initial begin
        clear    = 1'b1;
        start    = 1'b0;
        n_ops    = '0;
        op_valid = 1'b0;
        op_data  = '0;
        repeat (3) @(negedge clk);
        check_reset("por");
        clear = 1'b0;

        op_list[0] = 16'd5;  op_list[1] = 16'd10; op_list[2] = 16'd20;
        run_burst("n3", 3, 0, 16'd35, 1'b0);

        run_burst("n0", 0, 0, 16'd0, 1'b0);

        op_list[0] = 16'hFFFF; op_list[1] = 16'h0002;
        run_burst("wrap", 2, 0, 16'h0001, OvfExp);

        op_list[0] = 16'd100; op_list[1] = 16'd23;
        run_burst("stall", 2, 4, 16'd123, 1'b0);

        run_abort();

        op_list[0] = 16'd7;
        run_burst("post", 1, 0, 16'd7, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "simulation timeout");
    end

endmodule

// File: doc/acc_sequencer.md
# acc_sequencer

Control-side initiator for the team's 16-bit load/transfer accumulator. It accepts a burst of N operands over a valid/ready stream and clears the accumulator. For each operand it drives the accumulator's input bus, load strobe and transfer strobe in the correct order. It then captures the final sum and reports it with a one-cycle done pulse. It sits between the operand source (register file or test stimulus) and the accumulator, replacing hand-driven strobes.

## Interface
- `WIDTH`, 16: operand and sum width; must equal the accumulator width.
- `CNT_W`, 4: width of the operand-count input; at most 2^CNT_W−1 operands per burst.

- `clk` in 1: single clock; all logic on the rising edge.
- `clear` in 1: synchronous, active-high reset.
- `start` in 1: begin a burst; sampled only in IDLE.
- `n_ops` in CNT_W: operand count, latched on an accepted `start`.
- `op_valid` in 1: operand available.
- `op_data` in WIDTH: operand value.
- `op_ready` out 1: sequencer can take an operand; high only in WAIT.
- `acc_in` out WIDTH: registered operand bus to the accumulator.
- `acc_load` out 1: accumulator load strobe.
- `acc_transf` out 1: accumulator transfer (add) strobe.
- `acc_clear_n` out 1: accumulator clear, active-low; registered and glitch-free.
- `acc_out` in WIDTH: accumulator sum.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse when `result` is valid.
- `result` out WIDTH: captured final sum; holds until the next capture.
- `ovf` out 1: sticky overflow flag for the current burst; see Configuration.

## Operation
- The FSM states are IDLE, CLR, WAIT, LOAD, ADD, FIN and DONE.
- All strobes are Moore-decoded from the registered state, with no combinational path from inputs to strobes:
  - `acc_clear_n` = 0 only in CLR.
  - `acc_load` = 1 only in LOAD.
  - `acc_transf` = 1 only in ADD.
- Transitions:
  - IDLE: `start` latches `n_ops` into the remaining counter `rem`, then goes to CLR.
  - CLR: if `rem` == 0, go to FIN; otherwise go to WAIT.
  - WAIT: `op_ready` = 1. When `op_valid` is high, register `op_data` into `acc_in` and go to LOAD. Otherwise stay in WAIT indefinitely.
  - LOAD → ADD, unconditionally.
  - ADD: decrement `rem`. If the pre-decrement `rem` is greater than 1, go to WAIT; otherwise go to FIN.
  - FIN: `result` <= `acc_out`, then go to DONE.
  - DONE: `done` = 1, then go to IDLE.
- `acc_in` is held stable from capture until the next WAIT handshake.
- `start` outside IDLE is ignored. `n_ops` changes after latching have no effect.
- Arithmetic wraps modulo 2^WIDTH, matching the accumulator.
- `clear` in any state forces the following reset values on the next edge, abandoning any burst in progress:
  - state = IDLE
  - `rem` = 0
  - `acc_in` = 0
  - `result` = 0
  - `ovf` = 0
  - `acc_clear_n` = 1
  - `acc_load` = 0
  - `acc_transf` = 0
  - `op_ready` = 0
  - `busy` = 0
  - `done` = 0
- A reset mid-burst leaves the accumulator contents undefined. The next burst's CLR cycle restores a clean state.

## Timing
- `start` → CLR in 1 cycle; `busy` rises on the same edge.
- Per operand: handshake cycle (WAIT), then LOAD, then ADD, for a minimum of 3 cycles with `op_valid` held high.
- `acc_out` reflects the new sum on the edge that ends ADD. FIN samples it one cycle later, which gives a safe margin.
- Burst latency from `start` to `done`, with a source that is always valid: 1 + 3·N + 2 cycles (CLR + per-operand + FIN/DONE). For N = 0 this is 3 cycles: CLR, FIN, DONE.
- `done` is high for exactly one cycle. IDLE follows, and a new `start` is accepted in that IDLE cycle.

## Configuration
- `ACC_SEQ_OVF_EN` defined:
  - A WIDTH+1-bit shadow sum is zeroed in CLR and adds `acc_in` in ADD.
  - `ovf` is set when bit WIDTH of the shadow sum becomes 1, and stays set until the next CLR or `clear`.
- Undefined: the shadow logic is absent and `ovf` is tied to 0.
- The port list is identical in both builds.

## Structure
- Shared package `acc_seq_pkg` holds:
  - the state encoding constants for IDLE through DONE,
  - the default WIDTH and CNT_W constants.
- A single flat module. No sub-module is warranted, because the FSM, counter and output registers are tightly coupled.
- The bench instantiates `acc_sequencer` together with the team's accumulator block, connecting strobes and data directly.

## Test plan
- Reset then N = 3, operands 5, 10, 20 with `op_valid` always high:
  - `done` pulses at cycle 12 after `start`,
  - `result` = 35, `ovf` = 0.
- N = 0: `result` = 0 and `done` arrives 3 cycles after `start`.
- N = 2, operands 0xFFFF and 0x0002:
  - `result` = 0x0001,
  - `ovf` = 1 with `ACC_SEQ_OVF_EN` defined; 0 without it.
- N = 2 with `op_valid` stalled 4 cycles before each operand:
  - `op_ready` stays high during the stalls,
  - `acc_load` and `acc_transf` never assert during the stalls,
  - `result` equals the correct sum.
- `start` pulsed while busy is ignored. `clear` asserted in LOAD of the second operand:
  - all outputs take their reset values the next cycle,
  - a following N = 1 burst of 7 yields `result` = 7.
- Strobe-order check on every operand: `acc_clear_n` is low only in CLR, and `acc_load` precedes `acc_transf` by exactly one cycle.
